// File: rtl/mux2_1.sv
// ----------------------------------------------------------------------------
// mux2_1 : parameterised 2:1 word multiplexer for datapath bus-select points.
//
// Provides a zero-latency combinational select, a one-cycle registered copy
// of that result, a registered copy of the select line, and a saturating
// count of clocked select-line changes for debug visibility.
//
// Parameters
//   WIDTH      data width of both inputs and of the data outputs
//   CNT_WIDTH  width of the select-toggle counter
//
// Ports
//   clk         in   1          rising-edge clock
//   clr         in   1          asynchronous active-high reset (registers only)
//   inputOne    in   WIDTH      data chosen when signal = 0
//   inputTwo    in   WIDTH      data chosen when signal = 1
//   signal      in   1          select line
//   out         out  WIDTH      combinational mux result
//   out_q       out  WIDTH      out delayed by one clock
//   sel_q       out  1          signal delayed by one clock
//   toggle_cnt  out  CNT_WIDTH  saturating count of clocked select changes
//
// Optional build macro: MUX2_1_PARITY_EN
//   Adds out_par   (XOR reduction of out, combinational) and
//        out_q_par (XOR reduction of out, registered alongside out_q).
// ----------------------------------------------------------------------------
module mux2_1 #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [WIDTH-1:0]     inputOne,
    input  logic [WIDTH-1:0]     inputTwo,
    input  logic                 signal,
    output logic [WIDTH-1:0]     out,
`ifdef MUX2_1_PARITY_EN
    output logic                 out_par,
    output logic                 out_q_par,
`endif
    output logic [WIDTH-1:0]     out_q,
    output logic                 sel_q,
    output logic [CNT_WIDTH-1:0] toggle_cnt
);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v)
            return v;
        else
            return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    logic [WIDTH-1:0]     data_p1;
    logic                 sel_p1;
    logic [CNT_WIDTH-1:0] cnt_p1;
    logic                 toggled;

    // ---- stage p0: combinational select ----
    // An unknown select yields an all-X word rather than silently favouring
    // one input; synthesis treats that arm as don't-care.
    always_comb begin
        case (signal)
            1'b0:    out = inputOne;
            1'b1:    out = inputTwo;
            default: out = {WIDTH{1'bx}};
        endcase
    end

    assign toggled = (signal != sel_p1);

    // ---- stage p1: registered copies and toggle counter ----
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            data_p1 <= '0;
            sel_p1  <= 1'b0;
            cnt_p1  <= '0;
        end else begin
            data_p1 <= out;
            sel_p1  <= signal;
            if (toggled)
                cnt_p1 <= sat_inc(cnt_p1);
        end
    end

    assign out_q      = data_p1;
    assign sel_q      = sel_p1;
    assign toggle_cnt = cnt_p1;

`ifdef MUX2_1_PARITY_EN
    logic par_p1;

    assign out_par = ^out;

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            par_p1 <= 1'b0;
        else
            par_p1 <= ^out;
    end

    assign out_q_par = par_p1;
`endif

endmodule

// File: tb/tb_mux2_1.sv
// ----------------------------------------------------------------------------
// tb_mux2_1 : directed self-checking bench for mux2_1.
// Two instances share the stimulus: the default build and one with a 2-bit
// toggle counter so saturation is reached quickly.
// ----------------------------------------------------------------------------
module tb_mux2_1;

    localparam int W  = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          clk_en = 1'b0;
    logic          clr = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          s = 1'b0;

    logic [W-1:0]  out, out_q, out2, out_q2;
    logic          sel_q, sel_q2;
    logic [CW-1:0] cnt;
    logic [1:0]    cnt2;
`ifdef MUX2_1_PARITY_EN
    logic          out_par, out_q_par, out_par2, out_q_par2;
`endif

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [W-1:0]  q;
        logic          sel;
        logic [CW-1:0] cnt;
        logic [1:0]    cnt2;
        logic          par;
    } exp_t;

    exp_t sb[$];

    // reference state
    logic          m_sel = 1'b0;
    logic [CW-1:0] m_cnt = '0;
    logic [1:0]    m_cnt2 = '0;

    always #5 if (clk_en) clk = ~clk;

    mux2_1 #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .clr(clr), .inputOne(a), .inputTwo(b), .signal(s),
        .out(out),
`ifdef MUX2_1_PARITY_EN
        .out_par(out_par), .out_q_par(out_q_par),
`endif
        .out_q(out_q), .sel_q(sel_q), .toggle_cnt(cnt)
    );

    mux2_1 #(.WIDTH(W), .CNT_WIDTH(2)) dut_small (
        .clk(clk), .clr(clr), .inputOne(a), .inputTwo(b), .signal(s),
        .out(out2),
`ifdef MUX2_1_PARITY_EN
        .out_par(out_par2), .out_q_par(out_q_par2),
`endif
        .out_q(out_q2), .sel_q(sel_q2), .toggle_cnt(cnt2)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_regs_zero(input string tag);
        check({tag, "_out_q"},  out_q, '0);
        check({tag, "_sel_q"},  {31'b0, sel_q}, '0);
        check({tag, "_cnt"},    {16'b0, cnt}, '0);
        check({tag, "_cnt2"},   {30'b0, cnt2}, '0);
`ifdef MUX2_1_PARITY_EN
        check({tag, "_q_par"},  {31'b0, out_q_par}, '0);
`endif
    endtask

    // Drive one vector after the falling edge, check the combinational path,
    // push the registered expectations, then pop and compare after the edge.
    task automatic step(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vs);
        exp_t e;
        exp_t got;
        logic [W-1:0] m_out;
        @(negedge clk);
        a = va; b = vb; s = vs;
        m_out = vs ? vb : va;
        #1;
        check({tag, "_out"}, out, m_out);
        check({tag, "_out_small"}, out2, m_out);
`ifdef MUX2_1_PARITY_EN
        check({tag, "_par"}, {31'b0, out_par}, {31'b0, ^m_out});
`endif
        if (vs != m_sel) begin
            if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
            if (m_cnt2 != 2'b11)     m_cnt2 = m_cnt2 + 1'b1;
        end
        m_sel = vs;
        e.q = m_out; e.sel = vs; e.cnt = m_cnt; e.cnt2 = m_cnt2; e.par = ^m_out;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({tag, "_out_q"}, out_q, got.q);
        check({tag, "_out_q_small"}, out_q2, got.q);
        check({tag, "_sel_q"}, {31'b0, sel_q}, {31'b0, got.sel});
        check({tag, "_cnt"}, {16'b0, cnt}, {16'b0, got.cnt});
        check({tag, "_cnt2"}, {30'b0, cnt2}, {30'b0, got.cnt2});
`ifdef MUX2_1_PARITY_EN
        check({tag, "_q_par"}, {31'b0, out_q_par}, {31'b0, got.par});
`endif
    endtask

    initial begin
        // Reset pulse with the clock stopped: registers clear immediately.
        #2 clr = 1'b1;
        #1 check_regs_zero("rst_noclk");
        #5 clr = 1'b0;
        #5 clk_en = 1'b1;

        step("sel0",  32'h0000_0001, 32'h0000_0002, 1'b0);
        step("sel1",  32'h0000_0001, 32'h0000_0002, 1'b1);
        step("max0",  32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        step("min1",  32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        step("hold1", 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        step("hold2", 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        for (int i = 0; i < 6; i++)
            step("tgl", 32'hA5A5_0000 + i, 32'h0F0F_0000 + i, i[0] ? 1'b1 : 1'b0);
        step("pre_rst", 32'h1234_5678, 32'h8000_0000, 1'b1);

        // Mid-stream reset: registers drop before the next edge, out stays live.
        @(negedge clk);
        clr = 1'b1;
        #1 check_regs_zero("rst_mid");
        a = 32'h0000_0003; b = 32'h0000_0001; s = 1'b0;
        #1 check("rst_out_live0", out, 32'h0000_0003);
`ifdef MUX2_1_PARITY_EN
        check("rst_par0", {31'b0, out_par}, 32'h0);
`endif
        s = 1'b1;
        #1 check("rst_out_live1", out, 32'h0000_0001);
`ifdef MUX2_1_PARITY_EN
        check("rst_par1", {31'b0, out_par}, 32'h1);
`endif
        @(posedge clk);
        #1 check_regs_zero("rst_hold");
        @(negedge clk);
        clr = 1'b0;
        m_sel = 1'b0; m_cnt = '0; m_cnt2 = '0;

        // First edge after release compares against sel_q=0.
        step("post_rst", 32'h0000_0005, 32'h0000_0006, 1'b1);
        step("post_rst0", 32'h0000_0005, 32'h0000_0006, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux2_1.md
Name: mux2_1

Overview:
- Parameterised 2:1 word multiplexer for the datapath bus-select points (e.g. choosing between a register value and an immediate/memory value).
- Provides:
  - a zero-latency combinational output;
  - a one-cycle registered copy of that output for timing-critical consumers;
  - a saturating count of select-line changes for debug/observability.

Parameters:
- WIDTH, 32, data width of both inputs and of the outputs.
- CNT_WIDTH, 16, width of the select-toggle counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  asynchronous, active-high reset.
- inputOne  input  WIDTH  data selected when signal=0.
- inputTwo  input  WIDTH  data selected when signal=1.
- signal  input  1  select line.
- out  output  WIDTH  combinational mux result.
- out_q  output  WIDTH  registered mux result, one cycle behind out.
- sel_q  output  1  registered copy of signal.
- toggle_cnt  output  CNT_WIDTH  number of clocked select changes, saturating.

Behaviour:
- Combinational path:
  - out = inputOne when signal=0; out = inputTwo when signal=1.
  - Purely combinational: no clock dependency and no latency. out settles within the same delta/timestep as any input change.
  - clr has no effect on out.
  - If signal is X/Z, out is X. No default priority is applied.
- Registered path, on each rising clk with clr low:
  - out_q <= out.
  - sel_q <= signal.
  - Latency is exactly 1 cycle.
- Toggle counter:
  - On each rising clk with clr low, if signal != sel_q, toggle_cnt increments by 1.
  - Saturates at all-ones and holds there; no wrap-around.
  - The first clock after reset release compares against sel_q=0, so signal=1 at that edge counts as one toggle.
- Reset:
  - clr high asynchronously forces out_q=0, sel_q=0 and toggle_cnt=0, immediately and independent of clk.
  - Values hold while clr is high.
  - clr asserted mid-operation discards the pending register state. out stays live throughout.
  - Deassertion is sampled on the next rising clk; the first capture occurs at that edge.
- Width rules:
  - Full-width pass-through: no sign extension, no truncation, and no arithmetic on the data.
  - Bit patterns 0x7FFFFFFF and 0x80000000 pass unchanged.
- Simultaneous data and select change at a clock edge: out_q captures the pre-edge settled out, following standard non-blocking semantics.

Optional Feature:
- Macro: MUX2_1_PARITY_EN.
- When defined:
  - Adds output out_par (1 bit) = even parity (XOR reduction) of out, combinational.
  - Adds output out_q_par (1 bit) = registered even parity of out, updated with out_q. It resets to 0 on clr.
- When undefined: neither port exists and there is no parity logic; all other behaviour is identical.

Test Plan:
- clr=1 pulse with no clock running -> out_q=0, sel_q=0 and toggle_cnt=0 immediately. Release clr before the remaining steps.
- inputOne=0x00000001, inputTwo=0x00000002, signal=0 -> out=0x00000001 within the same timestep; out_q=0x00000001 after the next rising clk.
- Same data, signal=1 -> out=0x00000002 combinationally; out_q=0x00000002 one cycle later; toggle_cnt increments by 1.
- inputOne=0x7FFFFFFF, inputTwo=0x80000000, signal=0 then 1 -> out=0x7FFFFFFF then 0x80000000 with no bit corruption. toggle_cnt gains exactly one count per select change, and none while signal is held for multiple cycles.
- Toggle signal every cycle with CNT_WIDTH overridden to 2 -> toggle_cnt reaches 3 and stays at 3.
- Assert clr mid-stream while out_q≠0 -> out_q, sel_q and toggle_cnt drop to 0 before the next edge while out keeps tracking inputs. With MUX2_1_PARITY_EN defined, inputOne=0x00000003 and signal=0 gives out_par=0; inputTwo=0x00000001 and signal=1 gives out_par=1.
